// File: rtl/mmc1_pkg.sv
// Shared definitions for the MMC1 serial register writer: register selects,
// shift length and the writer FSM state type.
package mmc1_pkg;

  localparam logic [1:0] REG_CONTROL = 2'b00;
  localparam logic [1:0] REG_CHR0    = 2'b01;
  localparam logic [1:0] REG_CHR1    = 2'b10;
  localparam logic [1:0] REG_PRG     = 2'b11;

  localparam int MMC1_SHIFT_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_GAP    = 2'd3
  } wr_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mmc1_phase_timer.sv
// Loadable down-counter timing one bus phase: terminal-count strobe plus a
// flag that is set once the count has fallen to the mark value.
module mmc1_phase_timer #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic [W-1:0] i_mark_val,
  output logic         o_tc,
  output logic         o_mark
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc   = (r_cnt == '0);
  assign o_mark = (r_cnt <= i_mark_val);

endmodule

// File: rtl/mmc1_serial_writer.sv
// Drives the MMC1 five-write serial protocol on the cartridge CPU pins.
// Define MMC1_WR_RESET_EN to honour REQ_RESET (prepends a D7=1 reset write).
module mmc1_serial_writer
  import mmc1_pkg::*;
#(
  parameter int M2_LOW_CYCLES  = 2,
  parameter int M2_HIGH_CYCLES = 3,
  parameter int ROMSEL_DELAY   = 1,
  parameter int GAP_CYCLES     = 1
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [1:0] REQ_REG,
  input  logic [4:0] REQ_DATA,
  input  logic       REQ_RESET,
  output logic       BUSY,
  output logic       DONE,
  output logic       CPU_M2,
  output logic       nCPU_ROMSEL,
  output logic       nCPU_RW,
  output logic       CPU_A14,
  output logic       CPU_A13,
  output logic       CPU_D0,
  output logic       CPU_D7,
  output wr_state_e  o_dbg_state
);

  localparam int PMAX = max3(M2_LOW_CYCLES, M2_HIGH_CYCLES, GAP_CYCLES);
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam logic [PW-1:0] LD_LOW  = PW'(M2_LOW_CYCLES - 1);
  localparam logic [PW-1:0] LD_HIGH = PW'(M2_HIGH_CYCLES - 1);
  localparam logic [PW-1:0] LD_GAP  = PW'(GAP_CYCLES - 1);
  // Count value in STROBE from which nROMSEL is driven low on the next clock.
  localparam logic [PW-1:0] MARK    = PW'(M2_HIGH_CYCLES - ROMSEL_DELAY);
  localparam logic [2:0]    LAST_BIT = 3'(MMC1_SHIFT_BITS - 1);

  wr_state_e   r_state;
  logic [4:0]  r_data;
  logic [2:0]  r_bit;
  logic        r_done, r_m2, r_nromsel, r_nrw, r_a14, r_a13, r_d0, r_d7;
  logic        w_accept, w_load, w_tc, w_mark, w_rst_pend, w_req_rst;
  logic [PW-1:0] w_load_val;
  logic [2:0]  w_bit_nxt;

  assign REQ_READY   = (r_state == ST_IDLE);
  assign BUSY        = ~REQ_READY;
  assign w_accept    = REQ_VALID & REQ_READY;
  assign w_bit_nxt   = r_bit + 3'd1;
  assign o_dbg_state = r_state;

`ifdef MMC1_WR_RESET_EN
  logic r_rst_pend;

  assign w_req_rst  = REQ_RESET;
  assign w_rst_pend = r_rst_pend;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rst_pend <= 1'b0;
    end else if (w_accept) begin
      r_rst_pend <= REQ_RESET;
    end else if (r_state == ST_GAP && w_tc) begin
      r_rst_pend <= 1'b0;
    end
  end
`else
  logic w_unused_req_reset;

  assign w_unused_req_reset = REQ_RESET;
  assign w_req_rst          = 1'b0;
  assign w_rst_pend         = 1'b0;
`endif

  // The timer is reloaded with the length of whichever phase comes next.
  assign w_load = (r_state == ST_IDLE) ? w_accept : w_tc;

  always_comb begin
    w_load_val = LD_LOW;
    case (r_state)
      ST_SETUP:  w_load_val = LD_HIGH;
      ST_STROBE: w_load_val = LD_GAP;
      default:   w_load_val = LD_LOW;
    endcase
  end

  mmc1_phase_timer #(.W(PW)) u_timer (
    .i_clk      (CLK),
    .i_rst_n    (nRST),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_mark_val (MARK),
    .o_tc       (w_tc),
    .o_mark     (w_mark)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ST_IDLE;
      r_data    <= '0;
      r_bit     <= '0;
      r_done    <= 1'b0;
      r_m2      <= 1'b0;
      r_nromsel <= 1'b1;
      r_nrw     <= 1'b1;
      r_a14     <= 1'b0;
      r_a13     <= 1'b0;
      r_d0      <= 1'b0;
      r_d7      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_state <= ST_SETUP;
          r_data  <= REQ_DATA;
          r_bit   <= '0;
          r_nrw   <= 1'b0;
          r_a14   <= REQ_REG[1];
          r_a13   <= REQ_REG[0];
          r_d7    <= w_req_rst;
          r_d0    <= REQ_DATA[0] & ~w_req_rst;
        end
        ST_SETUP: if (w_tc) begin
          r_state <= ST_STROBE;
          r_m2    <= 1'b1;
        end
        ST_STROBE: begin
          if (w_tc) begin
            r_state   <= ST_GAP;
            r_m2      <= 1'b0;
            r_nromsel <= 1'b1;
            r_nrw     <= 1'b1;
          end else begin
            r_nromsel <= ~w_mark;
          end
        end
        ST_GAP: if (w_tc) begin
          // Address/data change only here, so they are stable across a full write.
          if (w_rst_pend) begin
            r_state <= ST_SETUP;
            r_nrw   <= 1'b0;
            r_d7    <= 1'b0;
            r_d0    <= r_data[0];
          end else if (r_bit == LAST_BIT) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_SETUP;
            r_nrw   <= 1'b0;
            r_bit   <= w_bit_nxt;
            r_d0    <= r_data[w_bit_nxt];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DONE        = r_done;
  assign CPU_M2      = r_m2;
  assign nCPU_ROMSEL = r_nromsel;
  assign nCPU_RW     = r_nrw;
  assign CPU_A14     = r_a14;
  assign CPU_A13     = r_a13;
  assign CPU_D0      = r_d0;
  assign CPU_D7      = r_d7;

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Self-checking bench for mmc1_serial_writer: every nROMSEL fall and DONE pulse
// is checked against expectations queued when the request was accepted.
module tb_mmc1_serial_writer;
  import mmc1_pkg::*;

  localparam int L = 2, H = 3, D = 1, G = 1, W = L + H + G;
`ifdef MMC1_WR_RESET_EN
  localparam bit RST_EN = 1'b1;
`else
  localparam bit RST_EN = 1'b0;
`endif

  logic       CLK = 1'b0, nRST = 1'b0;
  logic       REQ_VALID = 1'b0, REQ_RESET = 1'b0;
  logic [1:0] REQ_REG = 2'b00;
  logic [4:0] REQ_DATA = 5'b0;
  logic       REQ_READY, BUSY, DONE;
  logic       CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7;
  wr_state_e  dbg_state;

  int n_tests = 0, n_fail = 0, cyc = 0, strobe_cnt = 0, last_done = -1;
  logic [35:0] exp_q[$];
  int          done_q[$];
  logic [35:0] mon_e;
  logic [3:0]  held_word = 4'b0;
  logic        prev_romsel = 1'b1;

  mmc1_serial_writer #(
    .M2_LOW_CYCLES(L), .M2_HIGH_CYCLES(H), .ROMSEL_DELAY(D), .GAP_CYCLES(G)
  ) dut (
    .CLK(CLK), .nRST(nRST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_REG(REQ_REG), .REQ_DATA(REQ_DATA), .REQ_RESET(REQ_RESET),
    .BUSY(BUSY), .DONE(DONE), .CPU_M2(CPU_M2), .nCPU_ROMSEL(nCPU_ROMSEL),
    .nCPU_RW(nCPU_RW), .CPU_A14(CPU_A14), .CPU_A13(CPU_A13),
    .CPU_D0(CPU_D0), .CPU_D7(CPU_D7), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] out_vec();
    return {CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7,
            DONE, BUSY, REQ_READY};
  endfunction

  // scoreboard monitor
  always @(negedge CLK) begin
    if (nRST && !nCPU_ROMSEL) begin
      if (prev_romsel) begin
        strobe_cnt++;
        held_word = {CPU_A14, CPU_A13, CPU_D7, CPU_D0};
        check("strobe_m2", 32'(CPU_M2), 32'd1);
        check("strobe_rw", 32'(nCPU_RW), 32'd0);
        if (exp_q.size() == 0) begin
          check("extra_strobe", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_word", 32'(held_word), 32'(mon_e[3:0]));
          check("strobe_cyc", cyc, mon_e[35:4]);
        end
      end else begin
        check("hold_word", 32'({CPU_A14, CPU_A13, CPU_D7, CPU_D0}), 32'(held_word));
      end
    end
    prev_romsel = nCPU_ROMSEL;
    if (nRST && DONE) begin
      check("ready_at_done", 32'(REQ_READY), 32'd1);
      if (done_q.size() == 0) check("extra_done", 32'd1, 32'd0);
      else check("done_cyc", cyc, done_q.pop_front());
      last_done = cyc;
    end
  end

  // driver: called at a negedge; returns at the negedge after acceptance with VALID still high
  task automatic send(input logic [1:0] rg, input logic [4:0] dt, input logic rs,
                      output int acc_cyc);
    int n = 0;
    int k = 0;
    int base;
    REQ_REG = rg; REQ_DATA = dt; REQ_RESET = rs; REQ_VALID = 1'b1;
    while (!REQ_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!REQ_READY) begin
      check("accept_timeout", 32'd0, 32'd1);
      REQ_VALID = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc;
    base = cyc + 1;
    if (rs && RST_EN) begin
      exp_q.push_back({32'(base + L + D), rg, 1'b1, 1'b0});
      k = 1;
    end
    for (int i = 0; i < 5; i++)
      exp_q.push_back({32'(base + (k + i) * W + L + D), rg, 1'b0, dt[i]});
    done_q.push_back(base + (k + 5) * W);
    @(negedge CLK);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0 || done_q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int acc, acc2, snap;
    repeat (3) @(negedge CLK);
    check("reset_outs", 32'(out_vec()), 32'b0110000001);
    nRST = 1'b1;
    @(negedge CLK);
    check("idle_outs", 32'(out_vec()), 32'b0110000001);

    // basic write, D0 sequence 0,1,1,0,1
    send(REG_PRG, 5'b10110, 1'b0, acc);
    REQ_VALID = 1'b0;
    wait_idle();
    check("done_31", last_done - acc, 32'd31);

    // reset write honoured only when the feature is built in
    send(REG_CONTROL, 5'b01110, 1'b1, acc);
    REQ_VALID = 1'b0;
    wait_idle();
    check("done_rst", last_done - acc, RST_EN ? 32'd37 : 32'd31);

    // back-to-back with VALID held high
    send(REG_CHR1, 5'b00011, 1'b0, acc);
    send(REG_CHR0, 5'b11001, 1'b0, acc2);
    REQ_VALID = 1'b0;
    check("b2b_accept", acc2, acc + 31);
    wait_idle();

    // VALID toggled while busy is ignored
    send(REG_CHR0, 5'b10011, 1'b0, acc);
    REQ_VALID = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      REQ_VALID = 1'($urandom_range(0, 1));
      REQ_DATA  = 5'($urandom_range(0, 31));
      REQ_REG   = 2'($urandom_range(0, 3));
      if (REQ_VALID) begin
        check("ready_busy", 32'(REQ_READY), 32'd0);
        check("busy_flag", 32'(BUSY), 32'd1);
      end
    end
    REQ_VALID = 1'b0;
    wait_idle();

    // random requests
    for (int i = 0; i < 4; i++) begin
      send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), acc);
      REQ_VALID = 1'b0;
      wait_idle();
    end

    // nRST during the third write's strobe
    snap = strobe_cnt;
    send(REG_PRG, 5'b11111, 1'b0, acc);
    REQ_VALID = 1'b0;
    for (int n = 0; n < 100 && strobe_cnt < snap + 3; n++) @(negedge CLK);
    check("third_strobe", strobe_cnt, snap + 3);
    #2 nRST = 1'b0;
    #1 check("async_rst_outs", 32'(out_vec()), 32'b0110000001);
    exp_q.delete();
    done_q.delete();
    snap = strobe_cnt;
    repeat (3) @(negedge CLK);
    #2 nRST = 1'b1;
    @(negedge CLK);
    check("ready_after_rst", 32'(REQ_READY), 32'd1);
    repeat (60) @(negedge CLK);
    check("no_strobe_after_rst", strobe_cnt, snap);

    check("q_empty", 32'(exp_q.size() + done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
